sram_like_resp: RTL and testbench
=================================

# sram_like_resp

Memory-side responder for the CPU's SRAM-like bus. It accepts requests from the CPU instruction or data port through the `req`/`addr_ok` address handshake and returns completions through `data_ok`/`rdata`. Completions are returned in order after a fixed latency. The block contains a word-addressed backing RAM and a bounded queue of outstanding requests. It is the slave end of the interface the CPU core drives, and it is instantiated once per CPU memory port in the SoC testbench.

## Interface
Parameters:
- `ADDR_W`, 16: log2 of RAM depth in 32-bit words; index = `addr[ADDR_W+1:2]`, higher address bits ignored
- `DELAY`, 2: cycles from address acceptance to `data_ok`; legal range 1..8
- `MAX_OUTST`, 4: maximum accepted-but-uncompleted requests; legal range 1..8

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req`  in  1  request valid
- `wr`  in  1  1 = write, 0 = read
- `size`  in  2  0 = byte, 1 = half, 2 = word; informational only, no effect on behaviour
- `wstrb`  in  4  byte enables for writes
- `addr`  in  32  byte address
- `wdata`  in  32  write data
- `hold`  in  1  test hook; forces `addr_ok` low
- `addr_ok`  out  1  request accepted this cycle
- `data_ok`  out  1  completion valid this cycle
- `rdata`  out  32  read data, valid while `data_ok` is high

## Operation
- **Accept condition:** `addr_ok = req & ~hold & (count < MAX_OUTST)`. This is combinational from the inputs and `count`. A request is accepted in a cycle where `req & addr_ok`.
- **Write on accept:** at the accepting edge, RAM bytes are written where `wstrb[i]` is set: byte i gets `wdata[8i+7:8i]`. A write with `wstrb == 0` changes nothing but still completes.
- **Read on accept:** at the accepting edge, the RAM word is read. The read observes all writes accepted in earlier cycles. The value is stored in the queue entry. Writes store `rdata = 0`.
- **Queue entry:** each entry holds `{rdata, cnt}`, where `cnt` is 3 bits. A new entry is pushed at the tail with `cnt = DELAY-1`.
- **Countdown:** every cycle, each valid entry with `cnt != 0` decrements `cnt`.
- **Completion:** `data_ok = (count != 0) & (head.cnt == 0)` and `rdata = head.rdata`. Both are combinational from registers.
- **Pop:** the head is removed at the end of any cycle in which `data_ok` is high.
- **Count update:** `count` changes by +1 on accept, -1 on pop, and 0 when both happen in the same cycle.
- **Circular buffer:** the queue uses head/tail pointers that wrap modulo `MAX_OUTST`.
- **Ordering:** completions are strictly in acceptance order, with exactly one `data_ok` per accepted request.
- **Throughput:** at most one accept and one completion per cycle.
- **No lookahead:** a pop in the same cycle does not make room for an accept in that cycle. `addr_ok` uses `count` before the pop.
- **Unchecked inputs:** alignment and `size`/`wstrb` consistency are not checked.
- **RAM reset behaviour:** RAM contents are not reset. A read of a never-written word returns X in simulation; the bench must write before it reads.

## Timing
- **Latency:** a request accepted in cycle t has `data_ok` high in cycle t+DELAY exactly, unless queued completions ahead of it push it later. With one accept per cycle and a fixed delay, it is never later.
- **Throughput:** back-to-back accepts give back-to-back `data_ok`, one per cycle.
- **Stall on full:** with `DELAY` > `MAX_OUTST`, accepts stall once `count == MAX_OUTST`. They resume in the cycle after the first pop.
- **Reset values:** while `reset` is high:
  - `addr_ok` = 0, `data_ok` = 0, `rdata` = 0.
  - `count` = 0, head/tail pointers = 0, all `cnt` = 0.
- **Reset mid-operation:** outstanding requests are discarded with no `data_ok`. RAM writes already accepted persist.
- **First cycle after reset:** deassertion is synchronised by the user. In the first cycle after deassertion the queue is empty and `addr_ok` follows `req & ~hold`.
- **Hold:** `hold` blocks accepts only. Outstanding requests keep counting down and complete normally.
- **Requester expectation:** the requester holds `req`, `wr`, `addr`, `wdata`, `wstrb` stable until accepted. The responder does not latch anything before the handshake.

## Test plan
- **Single write then read:** DELAY=2. Write `addr=0x100`, `wdata=0xDEADBEEF`, `wstrb=0xF` accepted in cycle 0 -> `data_ok` in cycle 2. Read `addr=0x100` accepted in cycle 1 -> `data_ok` in cycle 3 with `rdata=0xDEADBEEF`.
- **Byte strobe:** write `0x11223344` with `wstrb=0xF`, then write `0xAABBCCDD` with `wstrb=0x5` to the same word -> a later read returns `0x11BB33DD`.
- **Full queue:** `DELAY=6`, `MAX_OUTST=4`, `req` held high for 8 cycles.
  - `addr_ok` is high in cycles 0-3 and low in cycles 4-6.
  - `data_ok` is high in cycles 6-9.
  - `addr_ok` goes high again in cycle 7.
- **Hold:** 2 reads outstanding, `hold=1` for 5 cycles -> both `data_ok` pulses arrive on schedule and `addr_ok` stays 0 while `hold=1`.
- **Reset mid-flight:** 3 reads accepted, then `reset` pulsed before any completion -> no `data_ok`, `count=0`. A subsequent read of a previously written word returns the written value.
- **Pointer wrap:** `MAX_OUTST=4`, 20 back-to-back reads of distinct pre-written words -> 20 `data_ok` pulses in order, each `rdata` matching its address.

Source files
------------

// File: rtl/sram_like_resp.sv
// Memory-side responder for an SRAM-like bus: word-addressed backing RAM plus an
// in-order completion queue that returns each request a fixed DELAY after acceptance.
module sram_like_resp #(
    parameter int ADDR_W    = 16,
    parameter int DELAY     = 2,
    parameter int MAX_OUTST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        hold,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [2:0]       CNT_INIT = 3'(DELAY - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTST);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTST - 1);

    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic [31:0]       rd_word;

    logic [31:0]       q_rdata [MAX_OUTST];
    logic [2:0]        q_cnt   [MAX_OUTST];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic accept;
    logic pop;

    // size and the sub-word / upper address bits carry no behaviour
    logic unused_bits;
    assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR)
            return '0;
        else
            return p + PTR_W'(1);
    endfunction

    assign idx     = addr[ADDR_W+1:2];
    assign rd_word = mem[idx];

    // reset gates addr_ok so nothing is accepted while the queue is being cleared
    assign addr_ok = ~reset & req & ~hold & (count < MAX_CNT);
    assign accept  = req & addr_ok;

    assign data_ok = (count != '0) & (q_cnt[head] == 3'd0);
    assign rdata   = q_rdata[head];
    assign pop     = data_ok;

    // Backing RAM is deliberately not reset so writes survive a mid-flight reset.
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i])
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < MAX_OUTST; i++) begin
                q_cnt[i]   <= 3'd0;
                q_rdata[i] <= 32'd0;
            end
        end else begin
            // Slots not in use always sit at cnt 0, so no separate valid bits are needed.
            for (int i = 0; i < MAX_OUTST; i++) begin
                if (q_cnt[i] != 3'd0)
                    q_cnt[i] <= q_cnt[i] - 3'd1;
            end

            if (accept) begin
                q_cnt[tail]   <= CNT_INIT;
                q_rdata[tail] <= wr ? 32'd0 : rd_word;
                tail          <= next_ptr(tail);
            end

            if (pop)
                head <= next_ptr(head);

            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_like_resp.sv
// Self-checking bench: two responders (DELAY=2 and DELAY=6, MAX_OUTST=4) driven from
// a vector table and hand sequences, completions checked against a timed scoreboard.
module tb_sram_like_resp;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_a, req_b;
    logic        wr, hold;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic        addr_ok_a, data_ok_a, addr_ok_b, data_ok_b;
    logic [31:0] rdata_a, rdata_b;

    localparam int DELAY_A = 2;
    localparam int DELAY_B = 6;

    sram_like_resp #(.ADDR_W(16), .DELAY(DELAY_A), .MAX_OUTST(4)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .hold(hold),
        .addr_ok(addr_ok_a), .data_ok(data_ok_a), .rdata(rdata_a)
    );

    sram_like_resp #(.ADDR_W(16), .DELAY(DELAY_B), .MAX_OUTST(4)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .hold(hold),
        .addr_ok(addr_ok_b), .data_ok(data_ok_b), .rdata(rdata_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          due;
    } sb_t;

    typedef struct {
        bit          w;
        logic [3:0]  strb;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    sb_t  sb_a[$];
    sb_t  sb_b[$];
    vec_t vecs[11];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return (32'h0100_0001 * 32'(i + 1)) ^ 32'hA5A5_0000;
    endfunction

    // completion monitor: every data_ok must match the oldest expected entry, on its due cycle
    always @(negedge clk) begin
        sb_t e;
        if (reset) begin
            sb_a.delete();
            sb_b.delete();
            check("rst_addr_ok_a", 32'(addr_ok_a), 32'd0);
            check("rst_data_ok_a", 32'(data_ok_a), 32'd0);
            check("rst_rdata_a", rdata_a, 32'd0);
            check("rst_addr_ok_b", 32'(addr_ok_b), 32'd0);
            check("rst_data_ok_b", 32'(data_ok_b), 32'd0);
            check("rst_rdata_b", rdata_b, 32'd0);
        end else begin
            if (data_ok_a) begin
                if (sb_a.size() == 0) begin
                    check("unexpected_data_ok_a", 32'd1, 32'd0);
                end else begin
                    e = sb_a.pop_front();
                    check("rdata_a", rdata_a, e.data);
                    check("latency_a", 32'(cyc), 32'(e.due));
                end
            end
            if (data_ok_b) begin
                if (sb_b.size() == 0) begin
                    check("unexpected_data_ok_b", 32'd1, 32'd0);
                end else begin
                    e = sb_b.pop_front();
                    check("rdata_b", rdata_b, e.data);
                    check("latency_b", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input bit b, input bit w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
        int  n;
        sb_t ent;
        wr = w; wstrb = s; addr = a; wdata = d; size = 2'd2;
        if (b) req_b = 1'b1; else req_a = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(b ? addr_ok_b : addr_ok_a) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!(b ? addr_ok_b : addr_ok_a)) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            ent.data = e;
            ent.due  = cyc + (b ? DELAY_B : DELAY_A);
            if (b) sb_b.push_back(ent); else sb_a.push_back(ent);
        end
        @(posedge clk); #1;
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_a.size() != 0 || sb_b.size() != 0) && n < 40) begin
            @(posedge clk);
            n++;
        end
        check("drain_a", 32'(sb_a.size()), 32'd0);
        check("drain_b", 32'(sb_b.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [14:0] exp_aok;
        logic [14:0] exp_dok;
        int          c0;

        vecs[0]  = '{1'b1, 4'hF, 32'h0000_0100, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 4'hF, 32'h0000_0100, 32'h0,        32'hDEADBEEF};
        vecs[2]  = '{1'b1, 4'hF, 32'h0000_0200, 32'h11223344, 32'h0};
        vecs[3]  = '{1'b1, 4'h5, 32'h0000_0200, 32'hAABBCCDD, 32'h0};
        vecs[4]  = '{1'b0, 4'h0, 32'h0000_0200, 32'h0,        32'h11BB33DD};
        vecs[5]  = '{1'b1, 4'hF, 32'h0000_0300, 32'hCAFEF00D, 32'h0};
        vecs[6]  = '{1'b1, 4'h0, 32'h0000_0300, 32'hFFFFFFFF, 32'h0};
        vecs[7]  = '{1'b0, 4'h0, 32'h0000_0300, 32'h0,        32'hCAFEF00D};
        vecs[8]  = '{1'b1, 4'hA, 32'h0000_0302, 32'h0000_0000, 32'h0};
        vecs[9]  = '{1'b0, 4'h0, 32'h0000_0300, 32'h0,        32'h00FE000D};
        vecs[10] = '{1'b0, 4'h0, 32'h0004_0100, 32'h0,        32'hDEADBEEF};

        reset = 1'b1; hold = 1'b0; req_a = 1'b1; req_b = 1'b1;
        wr = 1'b0; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0; size = 2'd2;
        repeat (3) @(posedge clk);
        #1;
        req_a = 1'b0; req_b = 1'b0; reset = 1'b0;

        // table: write/read, byte strobes, zero strobe, ignored upper address bits
        for (int i = 0; i < 11; i++)
            send(1'b0, vecs[i].w, vecs[i].strb, vecs[i].a, vecs[i].d, vecs[i].exp);
        drain();

        // hold with two reads in flight
        send(1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 32'hDEADBEEF);
        send(1'b0, 1'b0, 4'h0, 32'h200, 32'h0, 32'h11BB33DD);
        hold = 1'b1; req_a = 1'b1; wr = 1'b0; addr = 32'h300;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_addr_ok_a", 32'(addr_ok_a), 32'd0);
            @(posedge clk); #1;
        end
        hold = 1'b0; req_a = 1'b0;
        drain();

        // full queue on the DELAY=6 instance, req held for cycles 0-7
        exp_aok = 15'h008F;
        exp_dok = 15'h23C0;
        wr = 1'b1; wstrb = 4'h0; addr = 32'h600; wdata = 32'h0; req_b = 1'b1;
        for (int k = 0; k < 15; k++) begin
            sb_t ent;
            @(negedge clk);
            check($sformatf("full_addr_ok_c%0d", k), 32'(addr_ok_b), 32'(exp_aok[k]));
            check($sformatf("full_data_ok_c%0d", k), 32'(data_ok_b), 32'(exp_dok[k]));
            if (exp_aok[k]) begin
                ent.data = 32'h0;
                ent.due  = cyc + DELAY_B;
                sb_b.push_back(ent);
            end
            @(posedge clk); #1;
            if (k == 7) req_b = 1'b0;
        end
        drain();

        // reset with three reads outstanding; RAM must keep its contents
        send(1'b1, 1'b1, 4'hF, 32'h500, 32'h5A5AA5A5, 32'h0);
        drain();
        for (int k = 0; k < 3; k++)
            send(1'b1, 1'b0, 4'h0, 32'h500, 32'h0, 32'h5A5AA5A5);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("flushed_data_ok_b", 32'(data_ok_b), 32'd0);
        end
        @(posedge clk); #1;
        c0 = cyc;
        for (int k = 0; k < 4; k++)
            send(1'b1, 1'b0, 4'h0, 32'h500, 32'h0, 32'h5A5AA5A5);
        check("post_reset_accept_cycles", 32'(cyc - c0), 32'd4);
        drain();

        // pointer wrap: 20 back-to-back writes then 20 back-to-back reads
        for (int i = 0; i < 20; i++)
            send(1'b0, 1'b1, 4'hF, 32'h1000 + 32'(4 * i), pat(i), 32'h0);
        for (int i = 0; i < 20; i++)
            send(1'b0, 1'b0, 4'h0, 32'h1000 + 32'(4 * i), 32'h0, pat(i));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
